// File: rtl/mmio_console_pkg.sv
// Shared constants for the MMIO console: register offsets, STATUS bit layout, default window base.
// Also provides the STATUS word packing helper used by the top level.
package mmio_console_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0000;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CLR    = 4'hC;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(input logic [23:0] cnt,
                                                input logic        ovf,
                                                input logic        full,
                                                input logic        empty);
        logic [31:0] s;
        s                     = '0;
        s[ST_COUNT_LSB +: 24] = cnt;
        s[ST_OVF]             = ovf;
        s[ST_FULL]            = full;
        s[ST_EMPTY]           = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// Processor data-bus port plus the valid/ready output word stream of the console.
// The console itself connects through the slave modport.
interface mmio_console_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output we, a, wd, out_ready,
        input  rd, sel, out_valid, out_data
    );

    modport slave (
        input  we, a, wd, out_ready,
        output rd, sel, out_valid, out_data
    );
endinterface

// File: rtl/mmio_console_fifo_sync.sv
// Synchronous FIFO with registered head (no bypass); extra pointer bit distinguishes full from empty.
// dout reads 0 while empty so the downstream data bus is clean after reset.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_en;
    logic             pop_en;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push
    assign pop_en  = pop & ~empty & ~reset;
    assign push_en = push & (~full | pop_en) & ~reset;

    assign wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: DATA stores feed an output word FIFO, CTRL requests halt, STATUS reports fill/overflow.
// Stores are never stalled; pushes into a full FIFO are dropped and flagged sticky in overflow.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [31:0] BASE  = DEFAULT_BASE,
    parameter int          DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_console_if.slave  bus,
    output logic           halt
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          sel_hit;
    logic [3:0]    off;
    logic          store;
    logic          wr_data, wr_ctrl, wr_clr;
    logic          fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_dout;
    logic          ovf_set;
    logic          ovf_q, ovf_d;
    logic          halt_req_q, halt_req_d;
    logic          eff_empty, eff_full, eff_ovf;
    logic [CW-1:0] eff_count;
    logic [31:0]   status;

    assign sel_hit = (bus.a[31:4] == BASE[31:4]);
    assign bus.sel = sel_hit;
    assign off     = {bus.a[3:2], 2'b00};

    assign store   = bus.we & sel_hit & ~reset;
    assign wr_data = store & (off == OFF_DATA);
    assign wr_ctrl = store & (off == OFF_CTRL);
    assign wr_clr  = store & (off == OFF_CLR);

    // Pop depends only on registered emptiness, keeping out_valid free of any path from out_ready
    assign fifo_pop = ~fifo_empty & bus.out_ready;

    fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (bus.wd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ovf_set    = wr_data & fifo_full & ~fifo_pop;
    assign ovf_d      = ovf_set ? 1'b1 : (wr_clr ? 1'b0 : ovf_q);
    assign halt_req_d = halt_req_q | wr_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            halt_req_q <= halt_req_d;
        end
    end

    // While reset is held, every visible output shows the post-reset view
    assign eff_empty = reset | fifo_empty;
    assign eff_full  = ~reset & fifo_full;
    assign eff_ovf   = ~reset & ovf_q;
    assign eff_count = reset ? '0 : fifo_count;

    assign status = pack_status(24'(eff_count), eff_ovf, eff_full, eff_empty);

    always_comb begin
        bus.rd = '0;
        if (sel_hit && (off == OFF_STATUS)) begin
            bus.rd = status;
        end
    end

    assign bus.out_valid = ~eff_empty;
    assign bus.out_data  = reset ? '0 : fifo_dout;
    assign halt          = ~reset & halt_req_q & fifo_empty;

endmodule

// File: tb/tb_mmio_console.sv
// Directed and randomized checks of mmio_console against a queue-based reference model.
module tb_mmio_console;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 8;

    logic clk;
    logic reset;
    logic halt;

    mmio_console_if bus ();

    mmio_console #(
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .halt  (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q[$];
    bit          ovf_m;
    bit          hreq_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status(input bit rs);
        int sz;
        sz = rs ? 0 : q.size();
        return (32'(sz) << 8) | ((ovf_m && !rs) ? 32'd4 : 32'd0) |
               ((sz == DEPTH) ? 32'd2 : 32'd0) | ((sz == 0) ? 32'd1 : 32'd0);
    endfunction

    task automatic check_outputs(input logic [31:0] ad, input bit rs);
        int          sz;
        logic [31:0] head;
        bit          in_win;
        sz     = rs ? 0 : q.size();
        head   = (sz > 0) ? q[0] : 32'd0;
        in_win = (ad[31:4] == BASE[31:4]);
        check("out_valid", {31'b0, bus.out_valid}, (sz > 0) ? 32'd1 : 32'd0);
        check("out_data", bus.out_data, head);
        check("halt", {31'b0, halt}, (!rs && hreq_m && sz == 0) ? 32'd1 : 32'd0);
        check("sel", {31'b0, bus.sel}, in_win ? 32'd1 : 32'd0);
        check("rd", bus.rd, (in_win && ad[3:2] == 2'd2) ? model_status(rs) : 32'd0);
    endtask

    task automatic model_step(input bit w, input logic [31:0] ad, input logic [31:0] d,
                              input bit r, input bit rs);
        bit hit;
        bit popping;
        int pre;
        if (rs) begin
            q.delete();
            ovf_m  = 0;
            hreq_m = 0;
            return;
        end
        hit     = w && (ad[31:4] == BASE[31:4]);
        pre     = q.size();
        popping = r && (pre > 0);
        if (popping) void'(q.pop_front());
        if (hit && ad[3:2] == 2'd3) ovf_m = 0;
        if (hit && ad[3:2] == 2'd0) begin
            if (pre < DEPTH || popping) q.push_back(d);
            else                        ovf_m = 1;
        end
        if (hit && ad[3:2] == 2'd1) hreq_m = 1;
    endtask

    // One clock cycle: drive, check pre-edge outputs, clock, advance model
    task automatic cyc(input bit w, input logic [31:0] ad, input logic [31:0] d,
                       input bit r, input bit rs);
        bus.we        = w;
        bus.a         = ad;
        bus.wd        = d;
        bus.out_ready = r;
        reset         = rs;
        #2;
        check_outputs(ad, rs);
        @(posedge clk);
        model_step(w, ad, d, r, rs);
        #1;
    endtask

    initial begin
        bus.we = 0; bus.a = 0; bus.wd = 0; bus.out_ready = 0; reset = 1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, BASE + 8, 0, 0, 1);
        check("rst_status", bus.rd, 32'h0000_0001);

        // Three stores, each word visible one cycle after its store
        cyc(1, BASE, 32'd5, 1, 0);
        check("seq_d0", bus.out_data, 32'd5);
        cyc(1, BASE, 32'(-3), 1, 0);
        check("seq_d1", bus.out_data, 32'hFFFF_FFFD);
        cyc(1, BASE, 32'd7, 1, 0);
        check("seq_d2", bus.out_data, 32'd7);
        cyc(0, BASE + 8, 0, 1, 0);
        cyc(0, BASE + 8, 0, 1, 0);
        check("seq_empty", bus.rd, 32'h0000_0001);

        // Overflow: nine stores with no consumer
        for (int i = 0; i < 9; i++) cyc(1, BASE, 32'h100 + 32'(i), 0, 0);
        cyc(0, BASE + 8, 0, 0, 0);
        check("ovf_status", bus.rd, 32'h0000_0806);
        for (int i = 0; i < 8; i++) begin
            check("ovf_order", bus.out_data, 32'h100 + 32'(i));
            cyc(0, BASE + 8, 0, 1, 0);
        end
        cyc(1, BASE + 12, 32'hDEAD, 0, 0);
        cyc(0, BASE + 8, 0, 0, 0);
        check("clr_status", bus.rd, 32'h0000_0001);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) cyc(1, BASE, 32'h200 + 32'(i), 0, 0);
        cyc(1, BASE, 32'h2FF, 1, 0);
        cyc(0, BASE + 8, 0, 0, 0);
        check("fullpp_status", bus.rd, 32'h0000_0802);
        for (int i = 0; i < 7; i++) cyc(0, BASE + 8, 0, 1, 0);
        check("fullpp_last", bus.out_data, 32'h2FF);
        cyc(0, BASE + 8, 0, 1, 0);

        // Halt waits for the drain, reset drops it
        cyc(1, BASE, 32'hA, 0, 0);
        cyc(1, BASE, 32'hB, 0, 0);
        cyc(1, BASE + 4, 32'h0, 0, 0);
        check("halt_held", {31'b0, halt}, 32'd0);
        cyc(0, 0, 0, 1, 0);
        check("halt_one_left", {31'b0, halt}, 32'd0);
        cyc(0, 0, 0, 1, 0);
        check("halt_rise", {31'b0, halt}, 32'd1);
        cyc(1, BASE, 32'hC, 0, 0);
        check("halt_push_ok", bus.out_data, 32'hC);
        cyc(0, 0, 0, 0, 1);
        check("halt_reset", {31'b0, halt}, 32'd0);

        // Stores outside the window
        cyc(1, BASE + 32'h10, 32'h55, 0, 0);
        check("oow_sel", {31'b0, bus.sel}, 32'd0);
        cyc(1, 32'h0, 32'h66, 0, 0);
        cyc(0, BASE + 8, 0, 0, 0);
        check("oow_status", bus.rd, 32'h0000_0001);

        // Reset mid-drain discards queued words
        for (int i = 0; i < 5; i++) cyc(1, BASE, 32'h300 + 32'(i), 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, BASE, 32'h3FF, 1, 1);
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc(0, BASE + 8, 0, 0, 0);
        check("mid_rst_status", bus.rd, 32'h0000_0001);
        cyc(1, BASE, 32'hA1, 0, 0);
        cyc(1, BASE, 32'hA2, 0, 0);
        check("mid_rst_fresh", bus.out_data, 32'hA1);
        cyc(0, 0, 0, 1, 0);
        check("mid_rst_fresh2", bus.out_data, 32'hA2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ad;
            int          pick;
            pick = int'($urandom_range(0, 11));
            case (pick)
                0, 1, 2, 3, 4: ad = BASE;
                5:             ad = BASE + 4;
                6, 7:          ad = BASE + 8;
                8:             ad = BASE + 12;
                9:             ad = BASE + 32'h10;
                10:            ad = BASE - 4;
                default:       ad = $urandom;
            endcase
            cyc($urandom_range(0, 9) < 7, ad, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 Parameter BASE, default 32'hFFFF_0000, word-aligned base address of the 16-byte register window.
REQ-002 Parameter DEPTH, default 8, output FIFO depth in 32-bit words; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  store strobe from the processor data bus, same timing as the data-memory write enable.
REQ-006 a  input  32  byte address from the processor data bus; bits [1:0] ignored.
REQ-007 wd  input  32  store data.
REQ-008 rd  output  32  combinational load data; 0 when a is outside the window.
REQ-009 sel  output  1  combinational flag, high when a[31:4] equals BASE[31:4]; used to steer the load mux away from data memory.
REQ-010 out_valid  output  1  FIFO head word available.
REQ-011 out_ready  input  1  consumer accepts the head word.
REQ-012 out_data  output  32  FIFO head word; holds its value while out_valid is high and out_ready is low.
REQ-013 halt  output  1  program-complete indication to the bench or top level.

Function
REQ-014 Register offsets within the window:
- 0x0 DATA: a store pushes wd; a load returns 0.
- 0x4 CTRL: a store of any value sets halt_req.
- 0x8 STATUS: read-only.
- 0xC CLR: a store of any value clears overflow.
REQ-015 STATUS load value: {count zero-extended to bits [31:8], 5'b0, overflow, full, empty}.
- count width is $clog2(DEPTH)+1.
REQ-016 Store decode requires we=1 and sel=1; stores outside the window SHALL have no effect.
REQ-017 Push to DATA when not full: wd enters the FIFO at the rising edge; out_valid rises after that same edge (1-cycle latency); no combinational bypass from wd to out_data.
REQ-018 Pop occurs on a rising edge with out_valid=1 and out_ready=1; out_data advances to the next word or out_valid falls.
REQ-019 The processor cannot stall, so a push when full and not popping in the same cycle is dropped and sets the sticky overflow bit.
REQ-020 Push and pop in the same cycle when full: the push is accepted, count is unchanged, overflow is not set.
REQ-021 Push and pop in the same cycle when empty: the push is accepted, there is no pop, and count becomes 1.
REQ-022 Pointers wrap modulo DEPTH; FIFO order is strictly preserved across wrap.
REQ-023 halt = halt_req AND empty; output drains before halt is asserted.
- halt_req is sticky until reset.
- DATA pushes after halt_req are still accepted.
REQ-024 Overflow clear and an overflowing push in the same cycle: overflow ends set (set wins).
REQ-025 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-026 reset high at a rising edge empties the FIFO and clears overflow and halt_req, including when asserted mid-stream; any words in flight are discarded.
REQ-027 Output values during and after reset: out_valid=0, halt=0, out_data=0, STATUS reads 32'h0000_0001.
REQ-028 Stores presented in a cycle where reset is high are ignored.

Structure
REQ-029 Shared package mmio_console_pkg holds:
- offset constants OFF_DATA, OFF_CTRL, OFF_STATUS, OFF_CLR;
- STATUS bit-index constants;
- the default BASE.
REQ-030 FIFO storage and pointers are isolated in one sub-module, fifo_sync (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-031 Address decode, status mux, and halt/overflow flags reside in mmio_console.

Verification
REQ-032 Reset, then three stores to BASE+0 of 5, -3, 7 with out_ready=1: out_data is 5, 0xFFFFFFFD, 7 on consecutive cycles, each starting one cycle after its store; then empty=1.
REQ-033 out_ready=0, nine stores to DATA with DEPTH=8: STATUS reads 0x0000_0806 (count 8, overflow, full); the first eight values drain in order; a store to CLR then gives STATUS 0x0000_0001.
REQ-034 FIFO full, store to DATA with out_ready=1 in the same cycle: count stays 8, overflow stays 0, the new word is delivered last.
REQ-035 Two words queued, out_ready=0, store to BASE+4: halt stays 0; raise out_ready: halt rises in the cycle after the second pop; a later reset drops halt.
REQ-036 Store to address BASE+0x10 and store to 0x0000_0000: no FIFO change, sel=0, rd=0.
REQ-037 Reset asserted with 5 words queued mid-drain: next cycle out_valid=0, STATUS=0x0000_0001, and no stale word reappears after subsequent pushes.
